// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Active-high 7-segment glyph constants ({g,f,e,d,c,b,a}) and
//                the BCD-to-glyph helper shared by display drivers.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Non-BCD codes render as a dash so corrupted counters stay visible.
    function automatic logic [6:0] bcd_to_seg7(input logic [3:0] bcd);
        logic [6:0] glyph;
        case (bcd)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_DASH;
        endcase
        return glyph;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational BCD digit to active-high 7-segment glyph.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = bcd_to_seg7(bcd);

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan
//  Description : Time-multiplexed N-digit 7-segment driver with anti-ghost
//                blanking, leading-zero suppression and per-frame snapshots.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIG       = 4,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned BLANK_CYC   = 16,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          AN_ACT_LOW  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4*N_DIG-1:0] digits_in,
    input  logic [N_DIG-1:0]   dp_in,
    input  logic               lz_en,
    output logic [6:0]         seg,
    output logic               dp,
    output logic [N_DIG-1:0]   an,
    output logic               frame_start
);

    localparam int unsigned      PRE_W     = $clog2(SCAN_DIV);
    localparam int unsigned      IDX_W     = $clog2(N_DIG);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIG - 1);
    localparam logic [N_DIG-1:0] AN_OFF    = {N_DIG{AN_ACT_LOW}};
    localparam logic [6:0]       SEG_PIN   = {7{SEG_ACT_LOW}};

    generate
        if (N_DIG < 2 || SCAN_DIV < 2 || BLANK_CYC == 0 || BLANK_CYC >= SCAN_DIV) begin : g_bad_param
            $error("seg7_scan: illegal parameter combination");
        end
    endgenerate

    logic [PRE_W-1:0] pre;
    logic [IDX_W-1:0] idx;
    logic [3:0]       snap [N_DIG];
    logic [N_DIG-1:0] dp_snap;
    logic [N_DIG-1:0] nonzero;
    logic [N_DIG-1:0] lz_blank;
    logic [6:0]       dec_seg;
    logic             frame_edge;
    logic [N_DIG-1:0] an_nxt;
    logic [6:0]       seg_nxt;
    logic             dp_nxt;

    assign frame_edge = (pre == '0) && (idx == '0);

    // A digit is a leading zero when it and every more significant digit are 0.
    generate
        for (genvar i = 0; i < N_DIG; i++) begin : g_lz
            assign nonzero[i] = |snap[i];
            if (i == 0) begin : g_lsd
                assign lz_blank[i] = 1'b0;
            end else begin : g_upper
                assign lz_blank[i] = lz_en & ~(|nonzero[N_DIG-1:i]);
            end
        end
    endgenerate

    seg7_decode u_decode (
        .bcd (snap[idx]),
        .seg (dec_seg)
    );

    always_comb begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_OFF ^ SEG_PIN;
        dp_nxt  = SEG_ACT_LOW;
        if (pre >= BLANK_END) begin
            an_nxt  = (N_DIG'(1) << idx) ^ AN_OFF;
            seg_nxt = (lz_blank[idx] ? SEG_OFF : dec_seg) ^ SEG_PIN;
            dp_nxt  = dp_snap[idx] ^ SEG_ACT_LOW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre         <= '0;
            idx         <= '0;
            dp_snap     <= '0;
            for (int i = 0; i < N_DIG; i++) snap[i] <= '0;
            an          <= AN_OFF;
            seg         <= SEG_OFF ^ SEG_PIN;
            dp          <= SEG_ACT_LOW;
            frame_start <= 1'b0;
        end else begin
            if (pre == PRE_LAST) begin
                pre <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
            if (frame_edge) begin
                for (int i = 0; i < N_DIG; i++) snap[i] <= digits_in[4*i +: 4];
                dp_snap <= dp_in;
            end
            frame_start <= frame_edge;
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp          <= dp_nxt;
        end
    end

endmodule
`default_nettype wire
